// File: rtl/svm_pkg.sv
// Shared definitions for the SVM window sequencer and the SVM stage it drives.
// Holds the sequencer state encoding, the default window/chain dimensions and
// a ceiling-log2 helper used to size address fields.
package svm_pkg;

  localparam int unsigned SVM_DIM    = 1024;
  localparam int unsigned SVM_MAXCOL = 10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE,
    SCORE,
    WAIT_K,
    REPORT
  } svm_state_e;

  // Ceiling log2, never below 1 so a degenerate size still yields a legal width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (value > (32'd1 << i)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/svm_window_sequencer_if.sv
// Control/address bundle between the window sequencer and its neighbours
// (pixel RAM, SV ROMs, alpha ROM, VU chain, scoring unit).
//   master: the sequencer -- drives addresses, strobes and the result.
//   slave : the environment -- drives start and the class bit.
// classIn carries the SVM stage sign bit ("class" is a reserved word).
interface svm_window_sequencer_if
  import svm_pkg::*;
#(
  parameter int unsigned ADDR_W  = clog2(SVM_DIM),
  parameter int unsigned MAXCOL  = SVM_MAXCOL,
  parameter int unsigned ALPHA_W = clog2(SVM_MAXCOL)
);
  logic                     start;
  logic                     busy;
  logic [ADDR_W-1:0]        pix_addr;
  logic                     pix_rd;
  logic [MAXCOL*ADDR_W-1:0] sv_addr;
  logic [ALPHA_W-1:0]       alpha_addr;
  logic                     resetVU;
  logic                     resetSU;
  logic                     enableVU;
  logic                     enableSU;
  logic                     mu;
  logic                     lastData;
  logic                     classIn;
  logic                     result_valid;
  logic                     class_out;
  logic [15:0]              win_count;

  modport master (
    input  start, classIn,
    output busy, pix_addr, pix_rd, sv_addr, alpha_addr, resetVU, resetSU,
           enableVU, enableSU, mu, lastData, result_valid, class_out, win_count
  );

  modport slave (
    output start, classIn,
    input  busy, pix_addr, pix_rd, sv_addr, alpha_addr, resetVU, resetSU,
           enableVU, enableSU, mu, lastData, result_valid, class_out, win_count
  );
endinterface

// File: rtl/svm_addr_skew.sv
// Register shift line producing the per-column SV ROM addresses: slot c holds
// the column-0 address delayed by c+1 registers relative to addrIn, so slot 0
// is the registered column-0 address and each further column lags by a cycle.
//   clock, reset : clock and async active-low reset (line clears to 0)
//   addrIn       : next-cycle column-0 address
//   addrLine     : column c at [c*ADDR_W +: ADDR_W]
module svm_addr_skew #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned MAXCOL = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        addrIn,
  output logic [MAXCOL*ADDR_W-1:0] addrLine
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addrLine <= '0;
    end else begin
      addrLine[0 +: ADDR_W] <= addrIn;
      for (int c = 1; c < int'(MAXCOL); c++) begin
        addrLine[c*ADDR_W +: ADDR_W] <= addrLine[(c-1)*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/svm_window_sequencer.sv
// Per-window control sequencer for the SVM stage: feeds DIM features with
// column-skewed SV addresses, strobes the VU chain (clear/accumulate/capture),
// steps alpha while the dot products shift out, then reports the class bit.
//   clock, reset : clock and async active-low reset
//   bus (master) : start/classIn in; addresses, strobes, busy, result out
// Every output except busy is a register loaded from the next-state decode,
// so each strobe lines up with the state it belongs to.
module svm_window_sequencer
  import svm_pkg::*;
#(
  parameter int unsigned DIM     = SVM_DIM,
  parameter int unsigned MAXCOL  = SVM_MAXCOL,
  parameter int unsigned MAC_LAT = 1,
  parameter int unsigned KER_LAT = 2,
  parameter int unsigned ADDR_W  = clog2(DIM),
  parameter int unsigned ALPHA_W = clog2(MAXCOL)
) (
  input logic                   clock,
  input logic                   reset,
  svm_window_sequencer_if.master bus
);

  localparam int unsigned DRAIN_LEN = MAXCOL + MAC_LAT;
  localparam int unsigned WAIT_W    = clog2(DRAIN_LEN + KER_LAT + 1);

  svm_state_e         state, stateNxt;
  logic [ADDR_W-1:0]  featCnt, featNxt;
  logic [ALPHA_W-1:0] colCnt, colNxt;
  logic [WAIT_W-1:0]  waitCnt, waitNxt;

  logic [ADDR_W-1:0]  pixAddr, pixAddrNxt;
  logic [ALPHA_W-1:0] alphaAddr, alphaAddrNxt;
  logic               pixRd, pixRdNxt;
  logic               resetVU, resetVUNxt;
  logic               resetSU, resetSUNxt;
  logic               enableVU, enableVUNxt;
  logic               enableSU, enableSUNxt;
  logic               mu, muNxt;
  logic               lastData, lastDataNxt;
  logic               resultValid, resultValidNxt;
  logic               classOut, classOutNxt;
  logic [15:0]        winCount, winCountNxt;
  logic [MAXCOL*ADDR_W-1:0] svAddr;

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      featCnt     <= '0;
      colCnt      <= '0;
      waitCnt     <= '0;
      pixAddr     <= '0;
      alphaAddr   <= '0;
      pixRd       <= 1'b0;
      resetVU     <= 1'b0;
      resetSU     <= 1'b0;
      enableVU    <= 1'b0;
      enableSU    <= 1'b0;
      mu          <= 1'b0;
      lastData    <= 1'b0;
      resultValid <= 1'b0;
      classOut    <= 1'b0;
      winCount    <= '0;
    end else begin
      state       <= stateNxt;
      featCnt     <= featNxt;
      colCnt      <= colNxt;
      waitCnt     <= waitNxt;
      pixAddr     <= pixAddrNxt;
      alphaAddr   <= alphaAddrNxt;
      pixRd       <= pixRdNxt;
      resetVU     <= resetVUNxt;
      resetSU     <= resetSUNxt;
      enableVU    <= enableVUNxt;
      enableSU    <= enableSUNxt;
      mu          <= muNxt;
      lastData    <= lastDataNxt;
      resultValid <= resultValidNxt;
      classOut    <= classOutNxt;
      winCount    <= winCountNxt;
    end
  end

  // Next state/counters, then outputs decoded from where we are heading.
  always_comb begin
    stateNxt       = state;
    featNxt        = featCnt;
    colNxt         = colCnt;
    waitNxt        = waitCnt;
    pixAddrNxt     = '0;
    alphaAddrNxt   = '0;
    pixRdNxt       = 1'b0;
    resetVUNxt     = 1'b0;
    resetSUNxt     = 1'b0;
    enableVUNxt    = 1'b0;
    enableSUNxt    = 1'b0;
    muNxt          = 1'b0;
    lastDataNxt    = 1'b0;
    resultValidNxt = 1'b0;
    classOutNxt    = classOut;
    winCountNxt    = winCount;

    case (state)
      IDLE:    if (bus.start) stateNxt = CLEAR;
      CLEAR: begin
        stateNxt = FEED;
        featNxt  = '0;
      end
      FEED: begin
        if (featCnt == ADDR_W'(DIM - 1)) begin
          stateNxt = DRAIN;
          waitNxt  = '0;
        end else begin
          featNxt = featCnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (waitCnt == WAIT_W'(DRAIN_LEN - 1)) stateNxt = CAPTURE;
        else waitNxt = waitCnt + WAIT_W'(1);
      end
      CAPTURE: begin
        stateNxt = SCORE;
        colNxt   = '0;
      end
      SCORE: begin
        if (colCnt == ALPHA_W'(MAXCOL - 1)) begin
          stateNxt = (KER_LAT == 0) ? REPORT : WAIT_K;
          waitNxt  = '0;
        end else begin
          colNxt = colCnt + ALPHA_W'(1);
        end
      end
      WAIT_K: begin
        if (waitCnt == WAIT_W'(KER_LAT - 1)) stateNxt = REPORT;
        else waitNxt = waitCnt + WAIT_W'(1);
      end
      REPORT:  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase

    case (stateNxt)
      CLEAR: begin
        resetVUNxt = 1'b1;
        resetSUNxt = 1'b1;
        pixRdNxt   = 1'b1;
      end
      FEED: begin
        enableVUNxt = 1'b1;
        // Prefetch the next feature while one remains; RAM latency is one cycle.
        if (featNxt != ADDR_W'(DIM - 1)) begin
          pixRdNxt   = 1'b1;
          pixAddrNxt = featNxt + ADDR_W'(1);
        end else begin
          lastDataNxt = 1'b1;
        end
      end
      CAPTURE: begin
        muNxt        = 1'b1;
        alphaAddrNxt = ALPHA_W'(MAXCOL - 1);
      end
      SCORE: begin
        enableSUNxt = 1'b1;
        // Alpha leads the shifted-out column by one cycle of ROM latency.
        if (colNxt != ALPHA_W'(MAXCOL - 1)) alphaAddrNxt = ALPHA_W'(MAXCOL - 2) - colNxt;
      end
      REPORT: begin
        resultValidNxt = 1'b1;
        classOutNxt    = bus.classIn;
        winCountNxt    = winCount + 16'd1;
      end
      default: ;
    endcase
  end

  svm_addr_skew #(
    .ADDR_W (ADDR_W),
    .MAXCOL (MAXCOL)
  ) uSkew (
    .clock    (clock),
    .reset    (reset),
    .addrIn   (pixAddrNxt),
    .addrLine (svAddr)
  );

  assign bus.busy         = (state != IDLE);
  assign bus.pix_addr     = pixAddr;
  assign bus.pix_rd       = pixRd;
  assign bus.sv_addr      = svAddr;
  assign bus.alpha_addr   = alphaAddr;
  assign bus.resetVU      = resetVU;
  assign bus.resetSU      = resetSU;
  assign bus.enableVU     = enableVU;
  assign bus.enableSU     = enableSU;
  assign bus.mu           = mu;
  assign bus.lastData     = lastData;
  assign bus.result_valid = resultValid;
  assign bus.class_out    = classOut;
  assign bus.win_count    = winCount;

endmodule

// File: tb/tb_svm_window_sequencer.sv
// Bench for svm_window_sequencer. Instance A is the small configuration
// (DIM=4, MAXCOL=3, MAC_LAT=1, KER_LAT=1) checked cycle by cycle against a
// hand-written trace; instance B is the default size with KER_LAT=0 and start
// tied high, checked on report timing and results.
module tb_svm_window_sequencer;

  logic clock = 1'b0;
  logic resetA, resetB;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit doneA = 1'b0;
  bit doneB = 1'b0;

  svm_window_sequencer_if #(.ADDR_W(2), .MAXCOL(3), .ALPHA_W(2)) busA ();
  svm_window_sequencer #(.DIM(4), .MAXCOL(3), .MAC_LAT(1), .KER_LAT(1)) dutA (
    .clock (clock),
    .reset (resetA),
    .bus   (busA)
  );

  svm_window_sequencer_if #(.ADDR_W(10), .MAXCOL(10), .ALPHA_W(4)) busB ();
  svm_window_sequencer #(.DIM(1024), .MAXCOL(10), .MAC_LAT(1), .KER_LAT(0)) dutB (
    .clock (clock),
    .reset (resetB),
    .bus   (busB)
  );

  typedef struct packed {
    logic       busy;
    logic       pixRd;
    logic [1:0] pixAddr;
    logic [1:0] sv0;
    logic [1:0] sv1;
    logic [1:0] sv2;
    logic [1:0] alpha;
    logic       rVU;
    logic       rSU;
    logic       eVU;
    logic       eSU;
    logic       mu;
    logic       last;
    logic       valid;
    logic       cls;
    logic [15:0] win;
  } trace_t;

  trace_t      traceQ[$];
  int          traceTQ[$];
  logic [16:0] resQA[$];
  logic        prevClsA;

  int unsigned relQB[$];
  logic [16:0] resQB[$];
  int unsigned baseB = 0;
  bit          idleChkB = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic trace_t sampleA();
    trace_t s;
    s.busy    = busA.busy;
    s.pixRd   = busA.pix_rd;
    s.pixAddr = busA.pix_addr;
    s.sv0     = busA.sv_addr[1:0];
    s.sv1     = busA.sv_addr[3:2];
    s.sv2     = busA.sv_addr[5:4];
    s.alpha   = busA.alpha_addr;
    s.rVU     = busA.resetVU;
    s.rSU     = busA.resetSU;
    s.eVU     = busA.enableVU;
    s.eSU     = busA.enableSU;
    s.mu      = busA.mu;
    s.last    = busA.lastData;
    s.valid   = busA.result_valid;
    s.cls     = busA.class_out;
    s.win     = busA.win_count;
    return s;
  endfunction

  // Hand-derived waveform for one small window, start accepted at t=0.
  function automatic trace_t expTrace(input int t, input logic cls, input logic prevCls,
                                      input logic [15:0] win);
    trace_t e;
    e         = '0;
    e.busy    = (t >= 1 && t <= 15);
    e.rVU     = (t == 1);
    e.rSU     = (t == 1);
    e.pixRd   = (t >= 1 && t <= 4);
    if (t >= 1 && t <= 4) e.pixAddr = 2'(t - 1);
    if (t >= 1 && t <= 4) e.sv0 = 2'(t - 1);
    if (t >= 2 && t <= 5) e.sv1 = 2'(t - 2);
    if (t >= 3 && t <= 6) e.sv2 = 2'(t - 3);
    e.eVU     = (t >= 2 && t <= 5);
    e.last    = (t == 5);
    e.mu      = (t == 10);
    if (t == 10) e.alpha = 2'd2;
    if (t == 11) e.alpha = 2'd1;
    e.eSU     = (t >= 11 && t <= 13);
    e.valid   = (t == 15);
    e.cls     = (t >= 15) ? cls : prevCls;
    e.win     = (t >= 15) ? win : win - 16'd1;
    return e;
  endfunction

  // One window on instance A; abortAt>0 resets the DUT in that cycle instead.
  task automatic runWindowA(input logic cls, input bit extra, input int abortAt,
                            input logic [15:0] expWin);
    int last;
    last = (abortAt != 0) ? abortAt - 1 : 20;
    busA.classIn = cls;
    busA.start   = 1'b1;
    for (int t = 0; t <= last; t++) begin
      traceQ.push_back(expTrace(t, cls, prevClsA, expWin));
      traceTQ.push_back(t);
    end
    if (abortAt == 0) resQA.push_back({cls, expWin});
    for (int t = 1; t <= last; t++) begin
      @(posedge clock); #1;
      busA.start = extra && (t == 3 || t == 7);
    end
    if (abortAt == 0) begin
      @(posedge clock); #1;
      prevClsA = cls;
    end else begin
      @(posedge clock); #2;
      resetA = 1'b0;
      #1;
      check("A outputs right after async reset", 64'(sampleA()), 64'(0));
      repeat (3) @(posedge clock);
      #1;
      check("A outputs while held in reset", 64'(sampleA()), 64'(0));
      resetA   = 1'b1;
      prevClsA = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  // Instance A scoreboard: per-cycle trace plus results on result_valid.
  always @(negedge clock) begin : monA
    trace_t      e;
    int          t;
    logic [16:0] r;
    if (traceQ.size() != 0) begin
      e = traceQ.pop_front();
      t = traceTQ.pop_front();
      check($sformatf("A trace t=%0d", t), 64'(sampleA()), 64'(e));
    end
    if (busA.result_valid) begin
      if (resQA.size() == 0) begin
        check("A result_valid with nothing expected", 64'(busA.result_valid), 64'(0));
      end else begin
        r = resQA.pop_front();
        check("A class_out/win_count at report", 64'({busA.class_out, busA.win_count}), 64'(r));
      end
    end
  end

  // Instance B scoreboard: report cycle, result, and the single idle gap.
  always @(negedge clock) begin : monB
    int unsigned rel;
    logic [16:0] r;
    if (idleChkB) begin
      check("B busy in gap after report", 64'(busB.busy), 64'(0));
      idleChkB = 1'b0;
    end
    if (busB.result_valid) begin
      if (relQB.size() == 0) begin
        check("B result_valid with nothing expected", 64'(busB.result_valid), 64'(0));
      end else begin
        rel = relQB.pop_front();
        r   = resQB.pop_front();
        check("B report cycle", 64'(cyc - baseB), 64'(rel));
        check("B class_out/win_count at report", 64'({busB.class_out, busB.win_count}), 64'(r));
        idleChkB = 1'b1;
      end
    end
  end

  initial begin : stimA
    busA.start   = 1'b0;
    busA.classIn = 1'b0;
    resetA       = 1'b0;
    prevClsA     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("A reset state", 64'(sampleA()), 64'(0));
    resetA = 1'b1;
    @(posedge clock); #1;
    runWindowA(1'b1, 1'b0, 0, 16'd1);
    runWindowA(1'b0, 1'b0, 0, 16'd2);
    runWindowA(1'b1, 1'b1, 0, 16'd3);
    runWindowA(1'b1, 1'b0, 12, 16'd4);
    runWindowA(1'b1, 1'b0, 0, 16'd1);
    doneA = 1'b1;
  end

  initial begin : stimB
    busB.start   = 1'b0;
    busB.classIn = 1'b1;
    resetB       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("B reset state",
          64'({busB.busy, busB.result_valid, busB.win_count, busB.pix_addr, busB.alpha_addr}), 64'(0));
    resetB = 1'b1;
    @(posedge clock); #1;
    baseB = cyc;
    relQB.push_back(1048); resQB.push_back({1'b1, 16'd1});
    relQB.push_back(2097); resQB.push_back({1'b0, 16'd2});
    relQB.push_back(3146); resQB.push_back({1'b1, 16'd3});
    busB.start = 1'b1;
    repeat (1500) @(posedge clock);
    #1;
    busB.classIn = 1'b0;
    repeat (1000) @(posedge clock);
    #1;
    busB.classIn = 1'b1;
    repeat (500) @(posedge clock);
    #1;
    busB.start = 1'b0;
    repeat (300) @(posedge clock);
    #1;
    doneB = 1'b1;
  end

  initial begin : finisher
    while (!(doneA && doneB) && cyc < 8000) @(posedge clock);
    #2;
    check("run completed within cycle budget", 64'(doneA && doneB), 64'(1));
    check("A leftover expectations", 64'(traceQ.size() + resQA.size()), 64'(0));
    check("B leftover expectations", 64'(relQB.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
